uart_packet_decode: RTL
=======================

UART_PACKET_DECODE -- requirements
Module: uart_packet_decode

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit; legal range is 4 or more.
REQ-002 SHALL have parameter IDLE_GAP_BITS, default 20, meaning the inter-byte line-idle time in bit periods after which a partial packet is discarded.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 SHALL have port packet, output, [PACKET_WIDTH-1:0][7:0]: last complete packet.
REQ-007 SHALL have port packet_valid, output, 1 bit: one-cycle pulse when packet updates.
REQ-008 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a bad stop bit.

Function
REQ-009 SHALL pass uart_rxd through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-010 SHALL implement the bit FSM with states IDLE, START, DATA, STOP.
REQ-011 IDLE -> START SHALL occur on a synchronized 1->0 transition, and SHALL load the bit counter with CLKS_PER_BIT/2 - 1.
REQ-012 START SHALL re-sample at mid-bit: if 0 -> DATA with counter CLKS_PER_BIT-1; if 1 -> IDLE (glitch rejected, no output activity).
REQ-013 DATA SHALL sample at each counter expiry, shifting right into an 8-bit register (LSB first); after bit 7 -> STOP.
REQ-014 STOP SHALL sample at mid stop bit: if 1, the byte is accepted; if 0, frame_error pulses, the partial packet and byte index are cleared, and the FSM returns to IDLE only after the line is sampled high.
REQ-015 The first accepted byte of a packet SHALL land in packet index PACKET_WIDTH-1 and the last in index 0, so the string "abcdefgh" reassembles as transmitted.
REQ-016 Bytes SHALL assemble in an internal shadow register; packet SHALL change only on completion and SHALL hold between completions.
REQ-017 On acceptance of byte PACKET_WIDTH, packet SHALL load from the shadow register and packet_valid SHALL pulse in the same cycle, one cycle after the stop-bit sample; the byte index SHALL wrap to 0.
REQ-018 The gap counter SHALL count cycles in IDLE while the byte index is non-zero; when it reaches IDLE_GAP_BITS*CLKS_PER_BIT, the byte index SHALL clear without any pulse.
REQ-019 A start edge SHALL clear the gap counter; a start edge coinciding with gap expiry SHALL begin byte 0 of a new packet.
REQ-020 Back-to-back frames SHALL be supported: a falling edge on the first cycle after STOP completes SHALL be accepted.
REQ-021 Counter widths SHALL derive from $clog2 of their maxima; no truncation SHALL occur at the default parameter values.

Reset
REQ-022 On rst: FSM = IDLE; counters = 0; byte index = 0; shadow register = 0; packet = 0; packet_valid = 0; frame_error = 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; after release, the FSM SHALL wait for a fresh falling edge and SHALL NOT treat a line already low as a start bit.

Structure
REQ-024 PACKET_WIDTH and the FSM state typedef SHALL live in the shared generated parameters header; no local redefinition.
REQ-025 SHALL instantiate one sub-module, uart_rx_byte, containing the synchronizer, bit FSM and bit counter and emitting byte/byte_valid/frame_error; packet assembly, gap timer and output registers stay in the top.

Verification (bench: CLKS_PER_BIT=4, IDLE_GAP_BITS=20, PACKET_WIDTH=8)
REQ-026 Send "abcdefgh" back-to-back -> exactly one packet_valid pulse; packet == "abcdefgh"; frame_error never asserts.
REQ-027 Send 0x61, then hold the stop bit at 0 -> one frame_error pulse; a following full "abcdefgh" yields packet == "abcdefgh".
REQ-028 Low glitch of 1 clk on idle line -> no state leaves IDLE beyond START; no pulses; the next valid packet decodes correctly.
REQ-029 Send "abc", idle 81 bit periods, send "abcdefgh" -> one packet_valid; packet == "abcdefgh".
REQ-030 Assert rst during bit 3 of byte 5 -> all outputs 0; re-send "12345678" -> packet == "12345678" with one pulse.
REQ-031 Two consecutive packets "abcdefgh","ABCDEFGH" -> two pulses spaced 80 bit periods; packet holds "abcdefgh" until the second pulse.

Source files
------------

// File: rtl/uart_packet_decode_pkg.sv
// uart_packet_decode_pkg
//   Shared parameters and types for the UART packet decoder.
//   PACKET_WIDTH : number of bytes that make up one packet
//   rx_state_e   : bit-level receive FSM states
package uart_packet_decode_pkg;

  localparam int PACKET_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver: input synchronizer, bit FSM and bit counter.
//   Ports:
//     clk           : clock, rising edge
//     rst           : asynchronous active-high reset
//     rxd_i         : raw asynchronous serial line (idle high)
//     byte_o        : last received byte (valid with byte_valid_o)
//     byte_valid_o  : one-cycle pulse, byte accepted with a good stop bit
//     frame_error_o : one-cycle pulse, stop bit sampled low
//     start_o       : falling edge seen while idle (start of a new frame)
//     idle_o        : receiver is in IDLE
module uart_rx_byte
  import uart_packet_decode_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_error_o,
  output logic       start_o,
  output logic       idle_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic             sync1_q;
  logic             sync2_q;
  logic [1:0]       fill_q;
  logic             prevRx_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             errWait_q;
  logic [7:0]       byte_q;
  logic             byteValid_q;
  logic             frameErr_q;
  logic             startEdge;

  // Two-flop synchronizer. prevRx_q only starts following the line once
  // the pipeline holds real samples, so a line that is already low when
  // reset releases never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      fill_q   <= 2'b00;
      prevRx_q <= 1'b0;
    end else begin
      sync1_q  <= rxd_i;
      sync2_q  <= sync1_q;
      fill_q   <= {fill_q[0], 1'b1};
      prevRx_q <= fill_q[1] ? sync2_q : 1'b0;
    end
  end

  assign startEdge = (state_q == IDLE) && prevRx_q && !sync2_q;

  // Bit FSM. The counter is loaded on entry to each bit and the line is
  // sampled when it reaches zero, which lands on the middle of every bit.
  // After a bad stop bit the FSM lingers in STOP until the line is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      errWait_q   <= 1'b0;
      byte_q      <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startEdge) begin
            state_q <= START;
            cnt_q   <= CNT_W'(CLKS_PER_BIT / 2 - 1);
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!sync2_q) begin
              state_q  <= DATA;
              cnt_q    <= CNT_W'(CLKS_PER_BIT - 1);
              bitIdx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q  <= {sync2_q, shift_q[7:1]};
            cnt_q    <= CNT_W'(CLKS_PER_BIT - 1);
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (errWait_q) begin
            if (sync2_q) begin
              errWait_q <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (cnt_q == '0) begin
            if (sync2_q) begin
              byte_q      <= shift_q;
              byteValid_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              errWait_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = byteValid_q;
  assign frame_error_o = frameErr_q;
  assign start_o       = startEdge;
  assign idle_o        = (state_q == IDLE);

endmodule

// File: rtl/uart_packet_decode.sv
// uart_packet_decode
//   Reassembles PACKET_WIDTH bytes from a UART line into a packet.
//   Ports:
//     clk          : clock, rising edge
//     rst          : asynchronous active-high reset
//     uart_rxd     : asynchronous serial line, 8N1, LSB first, idle high
//     packet       : last complete packet, first received byte in the top index
//     packet_valid : one-cycle pulse when packet updates
//     frame_error  : one-cycle pulse on a bad stop bit
module uart_packet_decode
  import uart_packet_decode_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int IDLE_GAP_BITS = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         uart_rxd,
  output logic [PACKET_WIDTH-1:0][7:0] packet,
  output logic                         packet_valid,
  output logic                         frame_error
);

  localparam int IDX_W   = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;
  localparam int GAP_MAX = IDLE_GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_WIDTH - 1);

  logic [7:0]                   rxByte;
  logic                         rxByteValid;
  logic                         rxFrameError;
  logic                         rxStart;
  logic                         rxIdle;

  logic [IDX_W-1:0]             byteIdx_q, byteIdx_d;
  logic [PACKET_WIDTH-1:0][7:0] shadow_q, shadow_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic [PACKET_WIDTH-1:0][7:0] packet_q, packet_d;
  logic                         packetValid_q, packetValid_d;
  logic [IDX_W-1:0]             slot;
  logic                         gapExpired;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uRxByte (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (uart_rxd),
    .byte_o       (rxByte),
    .byte_valid_o (rxByteValid),
    .frame_error_o(rxFrameError),
    .start_o      (rxStart),
    .idle_o       (rxIdle)
  );

  // First byte of a packet goes to the highest index.
  assign slot       = LAST_IDX - byteIdx_q;
  assign gapExpired = (gap_q == GAP_W'(GAP_MAX));

  // Packet assembly: bytes collect in the shadow register and are copied
  // to the output only when the last byte arrives. A frame error or a
  // too-long idle gap throws away the partial packet.
  always_comb begin
    byteIdx_d     = byteIdx_q;
    shadow_d      = shadow_q;
    packet_d      = packet_q;
    packetValid_d = 1'b0;
    if (rxFrameError) begin
      byteIdx_d = '0;
      shadow_d  = '0;
    end else if (rxByteValid) begin
      shadow_d[slot] = rxByte;
      if (byteIdx_q == LAST_IDX) begin
        packet_d      = shadow_d;
        packetValid_d = 1'b1;
        byteIdx_d     = '0;
        shadow_d      = '0;
      end else begin
        byteIdx_d = byteIdx_q + 1'b1;
      end
    end else if (gapExpired) begin
      byteIdx_d = '0;
      shadow_d  = '0;
    end
  end

  // Gap timer runs only while idle mid-packet; a start edge restarts it.
  always_comb begin
    gap_d = gap_q + 1'b1;
    if (rxStart || !rxIdle || (byteIdx_q == '0) || gapExpired) begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byteIdx_q     <= '0;
      shadow_q      <= '0;
      gap_q         <= '0;
      packet_q      <= '0;
      packetValid_q <= 1'b0;
    end else begin
      byteIdx_q     <= byteIdx_d;
      shadow_q      <= shadow_d;
      gap_q         <= gap_d;
      packet_q      <= packet_d;
      packetValid_q <= packetValid_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = packetValid_q;
  assign frame_error  = rxFrameError;

endmodule
